// File: rtl/poly_mau_result_capture.sv
// poly_mau_result_capture
//   Captures {poly_mau_o1, poly_mau_o0} result pairs from POLY_MAU into a small
//   FIFO during a capture window. A start pulse arms the window. The window
//   closes after EXP_CNT results or after TIMEOUT cycles. The local-bus side
//   pops the results at any time.
//
//   Optional feature: define POLY_CAP_LATENCY_EN to build the start-to-first-valid
//   latency counter. Without it, lat_cycles is tied to 0.
//
// Ports
//   clk, rst_n          clock (rising edge) and async active-low reset
//   start               1-cycle arm pulse; flushes the FIFO and clears the flags
//   mau_valid/o0/o1     POLY_MAU result strobe and data words
//   rd_req              1-cycle pop request
//   rd_data, rd_vld     popped {o1,o0}; registered, valid the cycle after rd_req
//   count               FIFO occupancy, 0..DEPTH
//   busy                window open (WAIT)
//   done                sticky: window closed
//   timeout             sticky: window closed by the cycle limit
//   overflow            sticky: a result was dropped because the FIFO was full
//   lat_cycles          start-to-first-result latency in cycles
module poly_mau_result_capture #(
  parameter int DATA_W  = 24,
  parameter int DEPTH   = 8,
  parameter int EXP_CNT = 1,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mau_valid,
  input  logic [DATA_W-1:0]        mau_o0,
  input  logic [DATA_W-1:0]        mau_o1,
  input  logic                     rd_req,
  output logic [2*DATA_W-1:0]      rd_data,
  output logic                     rd_vld,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic                     overflow,
  output logic [7:0]               lat_cycles
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 16;
  localparam logic [RW-1:0] EXP_V  = RW'(EXP_CNT);
  localparam logic [7:0]    TO_V   = 8'(TIMEOUT);
  localparam logic [CW-1:0] FULL_V = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t state, state_nxt;

  logic [RW-1:0] res_cnt, res_nxt;
  logic [7:0]    cyc_cnt, cyc_nxt;
  logic          in_wait, take, hit_cnt, hit_to, close;
  logic          full, empty, push, pop, ovf_set;
  logic [AW-1:0] wptr, rptr;
  logic [2*DATA_W-1:0] mem [DEPTH];

  // A result that arrives in the start cycle belongs to neither window.
  assign in_wait = (state == S_WAIT);
  assign take    = in_wait && mau_valid && !start;
  assign res_nxt = res_cnt + 1'b1;
  assign cyc_nxt = cyc_cnt + 1'b1;
  assign hit_cnt = take && (res_nxt == EXP_V);
  assign hit_to  = in_wait && !start && (cyc_nxt == TO_V);
  assign close   = hit_cnt || hit_to;
  assign busy    = in_wait;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start)               state_nxt = S_WAIT;
    else if (in_wait && close) state_nxt = S_DONE;
  end

  // ---------------- window counters and flags ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_cnt  <= '0;
      cyc_cnt  <= '0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      overflow <= 1'b0;
    end else if (start) begin
      res_cnt  <= '0;
      cyc_cnt  <= '0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (in_wait) cyc_cnt <= cyc_nxt;
      if (take)    res_cnt <= res_nxt;
      if (close) begin
        done    <= 1'b1;
        // When the count and the time limit coincide, the count wins.
        timeout <= !hit_cnt;
      end
      if (ovf_set) overflow <= 1'b1;
    end
  end

  // ---------------- FIFO ----------------
  assign full  = (count == FULL_V);
  assign empty = (count == '0);
  // A pop frees a slot in the same cycle, so a push into a full FIFO is kept
  // when a pop accompanies it. A pop that coincides with start is discarded
  // because the flush empties the FIFO anyway.
  assign pop     = rd_req && !empty && !start;
  assign push    = take && (!full || pop);
  assign ovf_set = take && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (start) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {mau_o1, mau_o0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_vld  <= 1'b0;
    end else begin
      rd_vld <= pop;
      if (pop) rd_data <= mem[rptr];
    end
  end

  // ---------------- latency measurement ----------------
`ifdef POLY_CAP_LATENCY_EN
  logic [7:0] lat_cnt, lat_nxt;
  logic       lat_got;

  // lat_nxt is the cycle count including the current cycle, so a result one
  // cycle after start reads as 1.
  assign lat_nxt = (lat_cnt == 8'hFF) ? lat_cnt : lat_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt    <= '0;
      lat_got    <= 1'b0;
      lat_cycles <= '0;
    end else if (start) begin
      lat_cnt    <= '0;
      lat_got    <= 1'b0;
      lat_cycles <= '0;
    end else begin
      lat_cnt <= lat_nxt;
      if (take && !lat_got) begin
        lat_cycles <= lat_nxt;
        lat_got    <= 1'b1;
      end
    end
  end
`else
  assign lat_cycles = '0;
`endif

endmodule

// File: tb/tb_poly_mau_result_capture.sv
module tb_poly_mau_result_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mau_valid, rd_req;
  logic [23:0] mau_o0, mau_o1;

  // default build: EXP_CNT=1
  logic [47:0] rd_data;
  logic        rd_vld, busy, done, timeout, overflow;
  logic [3:0]  count;
  logic [7:0]  lat_cycles;

  // EXP_CNT=12 build for FIFO fill/overflow scenarios
  logic [47:0] rd_data12;
  logic        rd_vld12, busy12, done12, timeout12, overflow12;
  logic [3:0]  count12;
  logic [7:0]  lat_cycles12;

  int checks = 0;
  int failures = 0;

`ifdef POLY_CAP_LATENCY_EN
  localparam logic [7:0] EXP_LAT = 8'd3;
`else
  localparam logic [7:0] EXP_LAT = 8'd0;
`endif

  always #5 clk = ~clk;

  poly_mau_result_capture u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mau_valid(mau_valid),
    .mau_o0(mau_o0), .mau_o1(mau_o1), .rd_req(rd_req),
    .rd_data(rd_data), .rd_vld(rd_vld), .count(count), .busy(busy),
    .done(done), .timeout(timeout), .overflow(overflow), .lat_cycles(lat_cycles)
  );

  poly_mau_result_capture #(.EXP_CNT(12)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .start(start), .mau_valid(mau_valid),
    .mau_o0(mau_o0), .mau_o1(mau_o1), .rd_req(rd_req),
    .rd_data(rd_data12), .rd_vld(rd_vld12), .count(count12), .busy(busy12),
    .done(done12), .timeout(timeout12), .overflow(overflow12), .lat_cycles(lat_cycles12)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; mau_valid = 0; rd_req = 0; mau_o0 = '0; mau_o1 = '0;
    step(); step();
    checks++; if ({rd_vld, busy, done, timeout, overflow} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {rd_vld, busy, done, timeout, overflow}); end
    checks++; if ({count, count12, rd_data, lat_cycles} !== '0) begin failures++; $display("FAIL reset_data got count=%0d count12=%0d rd_data=%h lat=%0d exp all 0", count, count12, rd_data, lat_cycles); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    pulse_start();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    step(); step();
    mau_valid = 1; mau_o0 = 24'h000123; mau_o1 = 24'h000456;
    step();
    mau_valid = 0;
    checks++; if ({busy, done, timeout} !== 3'b010) begin failures++; $display("FAIL basic_close got busy/done/timeout=%b exp=010", {busy, done, timeout}); end
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", count); end
    checks++; if (lat_cycles !== EXP_LAT) begin failures++; $display("FAIL basic_lat got=%0d exp=%0d", lat_cycles, EXP_LAT); end
    // a valid in DONE is ignored
    mau_valid = 1; step(); mau_valid = 0;
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL basic_done_ignore got=%0d exp=1", count); end
    rd_req = 1; step(); rd_req = 0;
    checks++; if (rd_vld !== 1'b1 || rd_data !== 48'h000456000123) begin failures++; $display("FAIL basic_read got vld=%b data=%h exp vld=1 data=000456000123", rd_vld, rd_data); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL basic_count_after got=%0d exp=0", count); end
    step();
    checks++; if (rd_vld !== 1'b0) begin failures++; $display("FAIL basic_vld_pulse got=%b exp=0", rd_vld); end
  endtask

  task automatic test_timeout();
    int n = 0;
    pulse_start();
    while (busy === 1'b1 && n < 40) begin n++; step(); end
    checks++; if (n !== 15) begin failures++; $display("FAIL timeout_len got=%0d exp=15", n); end
    checks++; if ({done, timeout, count} !== {2'b11, 4'd0}) begin failures++; $display("FAIL timeout_flags got done=%b timeout=%b count=%0d exp 1 1 0", done, timeout, count); end
    pulse_start();
    checks++; if ({busy, done, timeout} !== 3'b100) begin failures++; $display("FAIL timeout_clear got busy/done/timeout=%b exp=100", {busy, done, timeout}); end
  endtask

  task automatic test_overflow();
    pulse_start();
    for (int i = 1; i <= 10; i++) begin
      mau_valid = 1; mau_o0 = 24'(i); mau_o1 = 24'(i);
      step();
    end
    mau_valid = 0;
    checks++; if (count12 !== 4'd8 || overflow12 !== 1'b1) begin failures++; $display("FAIL ovf_state got count=%0d ovf=%b exp 8 1", count12, overflow12); end
    checks++; if (busy12 !== 1'b1 || done12 !== 1'b0) begin failures++; $display("FAIL ovf_window got busy=%b done=%b exp 1 0", busy12, done12); end
    for (int i = 1; i <= 8; i++) begin
      rd_req = 1; step();
      checks++; if (rd_vld12 !== 1'b1 || rd_data12 !== {24'(i), 24'(i)}) begin failures++; $display("FAIL ovf_pop%0d got vld=%b data=%h exp vld=1 data=%h", i, rd_vld12, rd_data12, {24'(i), 24'(i)}); end
    end
    rd_req = 0;
    checks++; if (count12 !== 4'd0) begin failures++; $display("FAIL ovf_drained got=%0d exp=0", count12); end
  endtask

  task automatic test_full_pop();
    logic [23:0] exp_q[8];
    pulse_start();
    checks++; if (overflow12 !== 1'b0 || count12 !== 4'd0) begin failures++; $display("FAIL fp_start_clear got ovf=%b count=%0d exp 0 0", overflow12, count12); end
    for (int i = 0; i < 8; i++) begin
      mau_valid = 1; mau_o0 = 24'h11 + 24'(i); mau_o1 = 24'h11 + 24'(i);
      step();
    end
    checks++; if (count12 !== 4'd8 || overflow12 !== 1'b0) begin failures++; $display("FAIL fp_full got count=%0d ovf=%b exp 8 0", count12, overflow12); end
    mau_o0 = 24'h99; mau_o1 = 24'h99; rd_req = 1;
    step();
    mau_valid = 0; rd_req = 0;
    checks++; if (count12 !== 4'd8 || overflow12 !== 1'b0) begin failures++; $display("FAIL fp_push_pop got count=%0d ovf=%b exp 8 0", count12, overflow12); end
    checks++; if (rd_vld12 !== 1'b1 || rd_data12 !== 48'h000011000011) begin failures++; $display("FAIL fp_oldest got vld=%b data=%h exp vld=1 data=000011000011", rd_vld12, rd_data12); end
    exp_q = '{24'h12, 24'h13, 24'h14, 24'h15, 24'h16, 24'h17, 24'h18, 24'h99};
    for (int i = 0; i < 8; i++) begin
      rd_req = 1; step();
      checks++; if (rd_data12 !== {exp_q[i], exp_q[i]}) begin failures++; $display("FAIL fp_drain%0d got=%h exp=%h", i, rd_data12, {exp_q[i], exp_q[i]}); end
    end
    rd_req = 0;
  endtask

  task automatic test_empty_restart();
    int n = 0;
    pulse_start();
    rd_req = 1; step(); rd_req = 0;
    checks++; if (rd_vld12 !== 1'b0 || count12 !== 4'd0) begin failures++; $display("FAIL empty_read got vld=%b count=%0d exp 0 0", rd_vld12, count12); end
    mau_valid = 1; mau_o0 = 24'hA; mau_o1 = 24'hB; step(); step(); mau_valid = 0;
    step(); step(); step();
    checks++; if (count12 !== 4'd2) begin failures++; $display("FAIL restart_pre got=%0d exp=2", count12); end
    pulse_start();
    checks++; if (count12 !== 4'd0 || busy12 !== 1'b1 || done12 !== 1'b0) begin failures++; $display("FAIL restart_flush got count=%0d busy=%b done=%b exp 0 1 0", count12, busy12, done12); end
    while (busy12 === 1'b1 && n < 40) begin n++; step(); end
    checks++; if (n !== 15 || timeout12 !== 1'b1) begin failures++; $display("FAIL restart_window got len=%0d timeout=%b exp 15 1", n, timeout12); end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    mau_valid = 1; mau_o0 = 24'h5; mau_o1 = 24'h6; step(); step(); mau_valid = 0;
    checks++; if (count12 !== 4'd2 || busy12 !== 1'b1) begin failures++; $display("FAIL rstmid_pre got count=%0d busy=%b exp 2 1", count12, busy12); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({count12, busy12, done12, timeout12, overflow12, rd_vld12} !== '0 || rd_data12 !== '0 || lat_cycles12 !== '0) begin failures++; $display("FAIL rstmid_async got count=%0d busy=%b done=%b exp all 0", count12, busy12, done12); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_overflow();
    test_full_pop();
    test_empty_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Runaway guard.
  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

endmodule
